// File: rtl/irq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// irq_ctrl_pkg
//   Shared types and constants for the external interrupt front-end.
//   - irq_state_t      : handshake FSM states (IDLE, REQ, ACKWAIT)
//   - IRQ_NSRC_MAX     : largest supported number of interrupt sources
//   - IRQ_SYNC_DEFAULT : default synchronizer depth per source
// ----------------------------------------------------------------------------
package irq_ctrl_pkg;

  localparam int IRQ_NSRC_MAX     = 16;
  localparam int IRQ_SYNC_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACKWAIT = 2'd2
  } irq_state_t;

endpackage : irq_ctrl_pkg

// File: rtl/irq_sync_edge.sv
// ----------------------------------------------------------------------------
// irq_sync_edge
//   Brings one asynchronous interrupt line into the CLOCK_50 domain and
//   produces a one-cycle pulse for each rising edge of the synchronized level.
//   Ports:
//     CLOCK_50 - system clock
//     reset    - asynchronous active-low reset
//     d        - raw asynchronous interrupt line
//     rise     - high for one cycle after a 0->1 transition is synchronized
// ----------------------------------------------------------------------------
module irq_sync_edge
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = IRQ_SYNC_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // r_prev resets to 0, so a line already high at reset release still
  // yields one rise once it has crossed the synchronizer.
  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : irq_sync_edge

// File: rtl/ext_irq_controller.sv
// ----------------------------------------------------------------------------
// ext_irq_controller
//   External interrupt front-end: latches rising edges on NSRC asynchronous
//   lines, arbitrates pending sources by fixed priority (lowest index wins)
//   and presents one request at a time to the processor.
//   Ports:
//     CLOCK_50     - system clock
//     reset        - asynchronous active-low reset
//     irq_src      - raw interrupt lines, rising-edge significant
//     irq_mask     - 1 = source eligible for arbitration
//     ovf_clear    - synchronous pulse clearing all overflow bits
//     ExtIAck      - processor acknowledge (level)
//     ExtIRQ       - registered request to processor
//     irq_id       - registered index of requested source (valid with ExtIRQ)
//     irq_pending  - pending register
//     irq_overflow - sticky: edge arrived while source already pending
// ----------------------------------------------------------------------------
module ext_irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter  int NSRC        = 4,
  parameter  int SYNC_STAGES = IRQ_SYNC_DEFAULT,
  localparam int IDW         = $clog2(NSRC)
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            ovf_clear,
  input  logic            ExtIAck,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] irq_pending,
  output logic [NSRC-1:0] irq_overflow
);

  irq_state_t      r_state, w_state_n;
  logic            r_irq, w_irq_n;
  logic [IDW-1:0]  r_id, w_id_n;
  logic [NSRC-1:0] r_pend, w_pend_n;
  logic [NSRC-1:0] r_ovf, w_ovf_n;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_eligible;
  logic            w_any;
  logic [IDW-1:0]  w_winner;
  logic            w_ack_clr;
  logic [NSRC-1:0] w_clr_mask;

  // Edge capture: one synchronizer/edge detector per source.
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .d       (irq_src[g]),
      .rise    (w_rise[g])
    );
  end

  // Fixed-priority encoder; scanning downward lets the lowest index win.
  assign w_eligible = r_pend & irq_mask;
  assign w_any      = |w_eligible;

  always_comb begin
    w_winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = IDW'(i);
    end
  end

  // Handshake FSM, next state and registered-output next values.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_n = r_state;
    w_irq_n   = r_irq;
    w_id_n    = r_id;
    w_ack_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_n = REQ;
          w_irq_n   = 1'b1;
          w_id_n    = w_winner;
        end
      end
      REQ: begin
        // Request is frozen until acknowledged; mask changes are ignored.
        if (ExtIAck) begin
          w_state_n = ACKWAIT;
          w_irq_n   = 1'b0;
          w_ack_clr = 1'b1;
        end
      end
      ACKWAIT: begin
        if (!ExtIAck) w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
        w_irq_n   = 1'b0;
      end
    endcase
  end

  // A rise on the source being retired at the same edge re-sets pending and
  // is not counted as an overflow. A new overflow beats ovf_clear.
  assign w_clr_mask = w_ack_clr ? (NSRC'(1) << r_id) : '0;
  assign w_pend_n   = (r_pend & ~w_clr_mask) | w_rise;
  assign w_ovf_n    = (r_ovf & ~{NSRC{ovf_clear}}) | (w_rise & r_pend & ~w_clr_mask);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
      r_id    <= '0;
      r_pend  <= '0;
      r_ovf   <= '0;
    end else begin
      r_state <= w_state_n;
      r_irq   <= w_irq_n;
      r_id    <= w_id_n;
      r_pend  <= w_pend_n;
      r_ovf   <= w_ovf_n;
    end
  end

  assign ExtIRQ       = r_irq;
  assign irq_id       = r_id;
  assign irq_pending  = r_pend;
  assign irq_overflow = r_ovf;

endmodule : ext_irq_controller

// File: tb/tb_ext_irq_controller.sv
// ----------------------------------------------------------------------------
// tb_ext_irq_controller
//   Self-checking bench for ext_irq_controller (NSRC=4, SYNC_STAGES=2).
//   Directed reset sequences, a table of per-cycle vectors, then randomized
//   stimulus compared against a behavioural model.
// ----------------------------------------------------------------------------
module tb_ext_irq_controller;

  localparam int NSRC = 4;
  localparam int S    = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] src;
  logic [3:0] mask;
  logic       oclr;
  logic       ack;
  logic       ext_irq;
  logic [1:0] irq_id;
  logic [3:0] pend;
  logic [3:0] ovf;

  int n_checks = 0;
  int n_fail   = 0;

  ext_irq_controller #(
    .NSRC       (NSRC),
    .SYNC_STAGES(S)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (rst_n),
    .irq_src     (src),
    .irq_mask    (mask),
    .ovf_clear   (oclr),
    .ExtIAck     (ack),
    .ExtIRQ      (ext_irq),
    .irq_id      (irq_id),
    .irq_pending (pend),
    .irq_overflow(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // A source counts as having risen at edge n when it was sampled high S
  // edges earlier and low the edge before that.
  bit [3:0] hist[$];
  bit [3:0] m_pend, m_ovf, m_rise, m_clr, m_elig;
  bit       m_busy, m_wait;
  int       m_id;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i <= S; i++) hist.push_back(4'h0);
    m_pend = '0;
    m_ovf  = '0;
    m_busy = 1'b0;
    m_wait = 1'b0;
    m_id   = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rise = hist[1] & ~hist[0];
      hist.push_back(src);
      void'(hist.pop_front());
      m_clr = '0;
      if (m_busy) begin
        if (ack) begin
          m_clr  = 4'(1 << m_id);
          m_busy = 1'b0;
          m_wait = 1'b1;
        end
      end else if (m_wait) begin
        if (!ack) m_wait = 1'b0;
      end else begin
        m_elig = m_pend & mask;
        if (m_elig != 0) begin
          m_busy = 1'b1;
          for (int i = 3; i >= 0; i--) if (m_elig[i]) m_id = i;
        end
      end
      m_ovf  = (oclr ? 4'h0 : m_ovf) | (m_rise & m_pend & ~m_clr);
      m_pend = (m_pend & ~m_clr) | m_rise;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] src;
    logic [3:0] mask;
    logic       ack;
    logic       oclr;
    logic       e_irq;
    logic [1:0] e_id;
    logic [3:0] e_pend;
    logic [3:0] e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] s, input logic [3:0] m, input logic a, input logic c,
                     input logic ei, input logic [1:0] eid, input logic [3:0] ep, input logic [3:0] eo);
    vec_t v;
    v.src = s; v.mask = m; v.ack = a; v.oclr = c;
    v.e_irq = ei; v.e_id = eid; v.e_pend = ep; v.e_ovf = eo;
    tbl.push_back(v);
  endtask

  initial begin
    // Single pulse on src2: grant 3 edges after sampling, one ack retires it.
    add(4'h4, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h4, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 2, 4'h4, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    // Simultaneous pulses on src3 and src1: 1 first, then 3.
    add(4'hA, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'hA, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 1, 4'hA, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h8, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h8, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 3, 4'h8, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    // Two pulses on src0 before ack: overflow, then ovf_clear.
    add(4'h1, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h1, 4'hF, 0, 0, 0, 0, 4'h1, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 0, 4'h1, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 0, 4'h1, 4'h1);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h1);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h1);
    add(4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    // Masked src0 pends without a request until unmasked.
    add(4'h1, 4'hE, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hE, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hE, 0, 0, 0, 0, 4'h1, 4'h0);
    add(4'h0, 4'hE, 0, 0, 0, 0, 4'h1, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 0, 4'h1, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    // Ack held 5 cycles: src0 pends meanwhile but is granted only after release.
    add(4'h2, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h2, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 1, 4'h2, 4'h0);
    add(4'h1, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h1, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h1, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h1, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h1, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 0, 4'h1, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    // Rise on src3 lands on its own ack edge: pending stays, second grant.
    add(4'h8, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h8, 4'h0);
    add(4'h8, 4'hF, 0, 0, 1, 3, 4'h8, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 3, 4'h8, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h8, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h8, 4'h0);
    add(4'h0, 4'hF, 0, 0, 1, 3, 4'h8, 4'h0);
    add(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    src   = 4'hF;
    mask  = 4'hF;
    oclr  = 1'b0;
    ack   = 1'b0;

    // Reset with all lines high: everything held at zero.
    repeat (3) @(negedge clk);
    check("rst_irq",  ext_irq, 0);
    check("rst_id",   irq_id,  0);
    check("rst_pend", pend,    0);
    check("rst_ovf",  ovf,     0);

    // Release: lines still high produce one rise each after the synchronizer.
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rel_pend_early", pend, 4'h0);
    @(negedge clk);
    check("rel_pend",     pend,    4'hF);
    check("rel_irq_late", ext_irq, 0);
    @(negedge clk);
    check("rel_irq", ext_irq, 1);
    check("rel_id",  irq_id,  0);

    // Reset while in REQ: request dropped immediately, nothing follows.
    #2;
    rst_n = 1'b0;
    src   = 4'h0;
    #1;
    check("midrst_irq",  ext_irq, 0);
    check("midrst_pend", pend,    0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_irq", ext_irq, 0);
    end
    check("postrst_pend", pend, 0);

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      src  = tbl[i].src;
      mask = tbl[i].mask;
      ack  = tbl[i].ack;
      oclr = tbl[i].oclr;
      @(negedge clk);
      check($sformatf("vec%0d_irq", i),  ext_irq, tbl[i].e_irq);
      if (tbl[i].e_irq) check($sformatf("vec%0d_id", i), irq_id, tbl[i].e_id);
      check($sformatf("vec%0d_pend", i), pend, tbl[i].e_pend);
      check($sformatf("vec%0d_ovf", i),  ovf,  tbl[i].e_ovf);
    end

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) src[b] = ~src[b];
      end
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
      ack  = ($urandom_range(0, 1) == 1);
      oclr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      check("rnd_irq",  ext_irq, m_busy);
      if (m_busy) check("rnd_id", irq_id, m_id);
      check("rnd_pend", pend, m_pend);
      check("rnd_ovf",  ovf,  m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ext_irq_controller
